// File: rtl/ir_queue.sv
// Instruction register fed by a small prefetch FIFO.
// Supports load, bypass on empty, bubble, flush and immediate extension.
module ir_queue #(
    parameter int INSTR_W = 32,
    parameter int OPC_W   = 6,
    parameter int REG_W   = 4,
    parameter int IMM_W   = 16,
    parameter int MODE_W  = 2,
    parameter int DEPTH   = 4,
    parameter int XLEN    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [INSTR_W-1:0]       in_instr,
    output logic                     in_ready,
    input  logic                     ir_write,
    input  logic                     flush,
    input  logic                     ext_signed,
    output logic                     ir_valid,
    output logic [OPC_W-1:0]         opcode,
    output logic [REG_W-1:0]         rs1,
    output logic [REG_W-1:0]         rd,
    output logic [IMM_W-1:0]         imm,
    output logic [MODE_W-1:0]        mode,
    output logic [XLEN-1:0]          imm_ext,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [OPC_W-1:0]  opc;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rd;
        logic [IMM_W-1:0]  imm;
        logic [MODE_W-1:0] mode;
    } fields_t;

    logic [INSTR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               push;
    logic               empty;
    logic               load;
    logic               bypass;
    logic               fifo_push;
    logic [INSTR_W-1:0] ir_next;
    fields_t            ir_q;

    assign in_ready  = (count != CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign push      = in_valid & in_ready;
    assign load      = ir_write & ~empty;
    // An empty queue hands the incoming word straight to the IR.
    assign bypass    = ir_write & empty & push;
    assign fifo_push = push & ~bypass;
    assign ir_next   = load ? mem[rd_ptr] : in_instr;

    always_ff @(posedge clk) begin
        if (fifo_push && !flush) begin
            mem[wr_ptr] <= in_instr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (load) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({fifo_push, load})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Fields hold across flush and bubbles; only ir_valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_valid <= 1'b0;
            ir_q     <= '0;
        end else if (flush) begin
            ir_valid <= 1'b0;
        end else if (ir_write) begin
            ir_valid <= load | bypass;
            if (load || bypass) begin
                ir_q <= fields_t'(ir_next);
            end
        end
    end

    assign opcode  = ir_q.opc;
    assign rs1     = ir_q.rs1;
    assign rd      = ir_q.rd;
    assign imm     = ir_q.imm;
    assign mode    = ir_q.mode;
    assign imm_ext = ext_signed ? XLEN'($signed(ir_q.imm))
                                : XLEN'(ir_q.imm);

endmodule
